float2int32_seq: RTL and testbench

- Multi-cycle converter from IEEE-754 single precision to 32-bit two's-complement integer. It is the inverse path of the int-to-float32 block.
- Format: sign[31], exponent[30:23] with bias 127, mantissa[22:0].
- Sits in the PE datapath between the float result bus and integer consumers.
- Valid/ready on both sides; an iterative shifter trades latency for area.

---
 rtl/f2i_pkg.sv | 9 +
 rtl/fp32_classify.sv | 34 +++
 rtl/float2int32_seq.sv | 138 +++++++++++++
 tb/tb_float2int32_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/f2i_pkg.sv
// f2i_pkg: shared FP32 field widths, integer limits and converter state encoding.
package f2i_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int EXP_BIAS = 127;
  localparam logic [31:0] INT32_MAX = 32'h7fff_ffff;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH, DONE} state_t;
endpackage

// File: rtl/fp32_classify.sv
// fp32_classify: decodes FP32 fields into special-case flags and shift direction/amount.
// F2I_ROUND_NEAREST_EN keeps e=-1 on the shift path so it can round up to 1.
module fp32_classify
  import f2i_pkg::*;
(
  input  logic             sign,
  input  logic [EXP_W-1:0] exp_f,
  input  logic [MAN_W-1:0] man,
  output logic             is_nan,
  output logic             is_inf,
  output logic             is_zero,
  output logic             sat,
  output logic             shift_left,
  output logic [4:0]       count
);
  localparam logic [7:0] E_LEFT = 8'(EXP_BIAS + MAN_W);
  localparam logic [7:0] E_SAT = 8'(EXP_BIAS + 31);
  localparam logic [7:0] E_HALF = 8'(EXP_BIAS - 1);
  logic special;
  always_comb begin
    is_nan = &exp_f && |man;
    is_inf = &exp_f && !(|man);
    // -2^31 is representable, so that one exponent-31 value takes the shift path
    sat = !(&exp_f) && exp_f >= E_SAT && !(sign && exp_f == E_SAT && !(|man));
`ifdef F2I_ROUND_NEAREST_EN
    is_zero = exp_f < E_HALF;
`else
    is_zero = exp_f <= E_HALF;
`endif
    special = is_nan | is_inf | sat | is_zero;
    shift_left = exp_f >= E_LEFT;
    count = special ? 5'd0 : shift_left ? 5'(exp_f - E_LEFT) : 5'(E_LEFT - exp_f);
  end
endmodule

// File: rtl/float2int32_seq.sv
// float2int32_seq: iterative FP32 to int32 converter, SHIFT_STEP bits per cycle.
// F2I_ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
module float2int32_seq
  import f2i_pkg::*;
#(
  parameter int SHIFT_STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_float,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_int,
  output logic        out_overflow,
  output logic        out_invalid
);
  localparam logic [5:0] STEP = 6'(SHIFT_STEP);
  state_t state_q, state_d;
  logic sign_q, sign_d, left_q, left_d, nan_q, nan_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [31:0] mag_q, mag_d, out_int_q, out_int_d, val;
  logic [4:0] count_q, count_d, amt;
  logic out_overflow_q, out_overflow_d, out_invalid_q, out_invalid_d;
  logic c_nan, c_inf, c_zero, c_sat, c_left;
  logic [4:0] c_count;
`ifdef F2I_ROUND_NEAREST_EN
  logic guard_q, guard_d, sticky_q, sticky_d;
`endif
  fp32_classify u_classify (
    .sign      (in_float[31]),
    .exp_f     (in_float[30:23]),
    .man       (in_float[22:0]),
    .is_nan    (c_nan),
    .is_inf    (c_inf),
    .is_zero   (c_zero),
    .sat       (c_sat),
    .shift_left(c_left),
    .count     (c_count)
  );
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_int = out_int_q;
  assign out_overflow = out_overflow_q;
  assign out_invalid = out_invalid_q;
  always_comb begin
    state_d = state_q;
    sign_d = sign_q;
    left_d = left_q;
    nan_d = nan_q;
    ovf_d = ovf_q;
    zero_d = zero_q;
    mag_d = mag_q;
    count_d = count_q;
    out_int_d = out_int_q;
    out_overflow_d = out_overflow_q;
    out_invalid_d = out_invalid_q;
    amt = (6'(count_q) < STEP) ? count_q : STEP[4:0];
`ifdef F2I_ROUND_NEAREST_EN
    guard_d = guard_q;
    sticky_d = sticky_q;
    val = mag_q + {31'd0, !left_q && guard_q && (sticky_q || mag_q[0])};
`else
    val = mag_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        sign_d = in_float[31];
        mag_d = {8'd0, 1'b1, in_float[22:0]};
        count_d = c_count;
        left_d = c_left;
        nan_d = c_nan;
        ovf_d = c_inf | c_sat;
        zero_d = c_zero;
`ifdef F2I_ROUND_NEAREST_EN
        guard_d = 1'b0;
        sticky_d = 1'b0;
`endif
        state_d = c_count != 5'd0 ? SHIFT : FINISH;
      end
      SHIFT: begin
        mag_d = left_q ? mag_q << amt : mag_q >> amt;
        count_d = count_q - amt;
`ifdef F2I_ROUND_NEAREST_EN
        // guard is the last bit out; everything before it folds into sticky
        if (!left_q) begin
          guard_d = mag_q[amt - 5'd1];
          sticky_d = sticky_q | guard_q | |(mag_q & ((32'd1 << (amt - 5'd1)) - 32'd1));
        end
`endif
        state_d = count_d == 5'd0 ? FINISH : SHIFT;
      end
      FINISH: begin
        out_int_d = (nan_q || zero_q) ? 32'd0 : ovf_q ? (sign_q ? INT32_MIN : INT32_MAX) :
                    sign_q ? 32'd0 - val : val;
        out_overflow_d = ovf_q;
        out_invalid_d = nan_q;
        state_d = DONE;
      end
      default: if (out_ready) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q <= 1'b0;
      left_q <= 1'b0;
      nan_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
      mag_q <= 32'd0;
      count_q <= 5'd0;
      out_int_q <= 32'd0;
      out_overflow_q <= 1'b0;
      out_invalid_q <= 1'b0;
`ifdef F2I_ROUND_NEAREST_EN
      guard_q <= 1'b0;
      sticky_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sign_q <= sign_d;
      left_q <= left_d;
      nan_q <= nan_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
      mag_q <= mag_d;
      count_q <= count_d;
      out_int_q <= out_int_d;
      out_overflow_q <= out_overflow_d;
      out_invalid_q <= out_invalid_d;
`ifdef F2I_ROUND_NEAREST_EN
      guard_q <= guard_d;
      sticky_q <= sticky_d;
`endif
    end
  end
endmodule

// File: tb/tb_float2int32_seq.sv
// tb_float2int32_seq: directed and random checks of float2int32_seq against an arithmetic reference.
module tb_float2int32_seq;
  localparam int STEP = 8;
`ifdef F2I_ROUND_NEAREST_EN
  localparam bit RN = 1'b1;
`else
  localparam bit RN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_float = 32'd0;
  logic in_ready, out_valid, out_overflow, out_invalid;
  logic [31:0] out_int;
  int n_vec = 0, n_err = 0;

  float2int32_seq #(.SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_float(in_float),
    .out_valid(out_valid), .out_ready(out_ready), .out_int(out_int),
    .out_overflow(out_overflow), .out_invalid(out_invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // value = 1.M * 2^e evaluated in 64-bit integers, then range-checked
  task automatic model(input logic [31:0] f, output logic [31:0] r, output logic ov,
                       output logic iv, output int lat);
    int e, k;
    longint m, q, rem, half, lim;
    e = int'(f[30:23]) - 127;
    m = longint'({1'b1, f[22:0]});
    r = 32'd0; ov = 1'b0; iv = 1'b0; lat = 2; k = 0;
    if (f[30:23] == 8'hff) begin
      iv = f[22:0] != 23'd0;
      ov = !iv;
      r = ov ? (f[31] ? 32'h8000_0000 : 32'h7fff_ffff) : 32'd0;
      return;
    end
    if (f[30:23] == 8'd0 || e < -1 || (e == -1 && !RN)) return;
    lim = f[31] ? 64'sh8000_0000 : 64'sh7fff_ffff;
    if (e >= 23) begin
      k = e - 23;
      q = (e > 40) ? lim + 1 : m <<< k;
    end else begin
      k = 23 - e;
      q = m >>> k;
      rem = m - (q <<< k);
      half = 64'sd1 <<< (k - 1);
      if (RN && (rem > half || (rem == half && q[0]))) q++;
    end
    if (q > lim) begin
      ov = 1'b1;
      r = f[31] ? 32'h8000_0000 : 32'h7fff_ffff;
      return;
    end
    r = f[31] ? 32'(-q) : 32'(q);
    lat = 2 + (k + STEP - 1) / STEP;
  endtask

  task automatic convert(input string tag, input logic [31:0] f, input logic [31:0] er,
                         input logic eo, input logic ei, input int el);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_float = f;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(el));
    chk({tag, ".out_int"}, out_int, er);
    chk({tag, ".overflow"}, 32'(out_overflow), 32'(eo));
    chk({tag, ".invalid"}, 32'(out_invalid), 32'(ei));
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".out_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] f, er;
    logic eo, ei;
    int el;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.out_int", out_int, 32'd0);
    chk("reset.flags", {30'd0, out_overflow, out_invalid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    convert("one", 32'h3F80_0000, 32'd1, 1'b0, 1'b0, 5);
    release_out("one");
    convert("big", 32'h4B00_0001, 32'd8388609, 1'b0, 1'b0, 2);
    release_out("big");
    convert("min", 32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 3);
    release_out("min");
    convert("p3_5", 32'h4060_0000, RN ? 32'd4 : 32'd3, 1'b0, 1'b0, 5);
    release_out("p3_5");
    convert("m2_5", 32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b0, 5);
    release_out("m2_5");
    convert("sat_pos", 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2);
    release_out("sat_pos");
    convert("ninf", 32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 2);
    release_out("ninf");
    convert("nan", 32'h7FC0_0000, 32'd0, 1'b0, 1'b1, 2);
    release_out("nan");
    convert("hold", 32'h3F80_0000, 32'd1, 1'b0, 1'b0, 5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_float = 32'h4000_0000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("hold.out_valid", 32'(out_valid), 32'd1);
      chk("hold.out_int", out_int, 32'd1);
      chk("hold.in_ready", 32'(in_ready), 32'd0);
      chk("hold.flags", {30'd0, out_overflow, out_invalid}, 32'd0);
    end
    in_valid = 1'b0;
    release_out("hold");
    @(negedge clk);
    in_float = 32'h3F80_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort.in_ready", 32'(in_ready), 32'd1);
    chk("abort.out_valid", 32'(out_valid), 32'd0);
    chk("abort.out_int", out_int, 32'd0);
    chk("abort.flags", {30'd0, out_overflow, out_invalid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    convert("two", 32'h4000_0000, 32'd2, 1'b0, 1'b0, 5);
    release_out("two");
    for (int i = 0; i < 40; i++) begin
      f = $urandom;
      if ($urandom_range(0, 3) != 0) f[30:23] = 8'($urandom_range(120, 162));
      if (i % 10 == 9) f[30:23] = 8'hff;
      model(f, er, eo, ei, el);
      convert($sformatf("rand%0d_%h", i, f), f, er, eo, ei, el);
      release_out("rand");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
